// File: rtl/seg7_pkg.sv
// Shared constants, segment decode and parameter legality helpers for the
// multiplexed seven-segment scan driver.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam int NUM_DIGITS_MIN  = 1;
  localparam int NUM_DIGITS_MAX  = 8;
  localparam int REFRESH_DIV_MIN = 2;

  // Segment bit 0 is 'a', bit 6 is 'g'; codes above 9 show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  function automatic bit seg7_params_ok(input int numDigits, input int refreshDiv);
    return (numDigits >= NUM_DIGITS_MIN) && (numDigits <= NUM_DIGITS_MAX) &&
           (refreshDiv >= REFRESH_DIV_MIN);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit decoder: one BCD code plus a blank request to the
// seven active-high segment drives.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_OFF : bcd_to_seg(code_i);

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment driver: prescaled digit scan with
// double-buffered BCD loads that only take effect at frame boundaries.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    enable_in,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load_in,
  input  logic                    blank_lz_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel_out,
  output logic                    frame_done_out
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  generate
    if (!seg7_params_ok(NUM_DIGITS, REFRESH_DIV)) begin : g_bad_params
      $error("seg7_scan_mux: NUM_DIGITS must be 1..8 and REFRESH_DIV >= 2");
    end
  endgenerate

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         stage_q, stage_d;
  logic [BW-1:0]         snap_q, snap_d;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  frameDone_q, frameDone_d;

  logic       tick;
  logic       boundary;
  logic [3:0] selCode;
  logic       selBlank;
  logic       zeroRun;
  logic [6:0] decSeg;

  assign tick     = enable_in && (presc_q == PRESC_LAST);
  assign boundary = tick && (idx_q == IDX_LAST);

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (tick) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else if (enable_in) begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Loads land in stage mid-frame; snap only changes on a frame boundary so
  // a digit never shows a mix of old and new values within one frame.
  always_comb begin
    stage_d   = stage_q;
    snap_d    = snap_q;
    pending_d = pending_q;
    if (load_in && boundary) begin
      snap_d    = bcd_in;
      pending_d = 1'b0;
    end else if (boundary && pending_q) begin
      snap_d    = stage_q;
      pending_d = 1'b0;
    end else if (load_in) begin
      stage_d   = bcd_in;
      pending_d = 1'b1;
    end
  end

  // Scan from the top digit down; a digit is a leading zero while every
  // digit at or above it is zero. Digit 0 always stays lit.
  always_comb begin
    selCode  = '0;
    selBlank = 1'b0;
    zeroRun  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeroRun = zeroRun && (snap_q[4*i +: 4] == 4'd0);
      if (idx_q == IW'(i)) begin
        selCode  = snap_q[4*i +: 4];
        selBlank = blank_lz_in && zeroRun && (i > 0);
      end
    end
  end

  seg7_decode u_decode (
    .code_i  (selCode),
    .blank_i (selBlank),
    .seg_o   (decSeg)
  );

  always_comb begin
    seg_d       = SEG_OFF;
    sel_d       = '0;
    frameDone_d = boundary;
    if (enable_in) begin
      seg_d = decSeg;
      sel_d = NUM_DIGITS'(1) << idx_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      presc_q     <= '0;
      idx_q       <= '0;
      stage_q     <= '0;
      snap_q      <= '0;
      pending_q   <= 1'b0;
      seg_q       <= '0;
      sel_q       <= '0;
      frameDone_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      stage_q     <= stage_d;
      snap_q      <= snap_d;
      pending_q   <= pending_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign seg_out        = seg_q;
  assign digit_sel_out  = sel_q;
  assign frame_done_out = frameDone_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: a frame-position reference model
// predicts every cycle's outputs and a negedge monitor compares them.
module tb_seg7_scan_mux;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int FRAME = ND * RD;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  typedef struct packed {
    logic [6:0]    seg;
    logic [ND-1:0] sel;
    logic          fd;
  } expT;

  logic            clk = 1'b0;
  logic            resetIn = 1'b1;
  logic            enableIn = 1'b0;
  logic [4*ND-1:0] bcdIn = '0;
  logic            loadIn = 1'b0;
  logic            blankLzIn = 1'b0;
  logic [6:0]      segOut;
  logic [ND-1:0]   digitSelOut;
  logic            frameDoneOut;

  expT expQ[$];
  int  checks = 0;
  int  errors = 0;
  int  cycle  = 0;

  // Reference state: position within the frame counted in enabled cycles,
  // plus the displayed and staged digit values.
  int  framePos = 0;
  int  snapD  [ND];
  int  stageD [ND];
  bit  pend = 1'b0;
  bit  blzMode = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk_in         (clk),
    .reset_in       (resetIn),
    .enable_in      (enableIn),
    .bcd_in         (bcdIn),
    .load_in        (loadIn),
    .blank_lz_in    (blankLzIn),
    .seg_out        (segOut),
    .digit_sel_out  (digitSelOut),
    .frame_done_out (frameDoneOut)
  );

  function automatic logic [6:0] expectedSeg(input int dg, input bit blz);
    bit allZero = 1'b1;
    for (int i = dg; i < ND; i++)
      if (snapD[i] != 0) allZero = 1'b0;
    if (blz && dg > 0 && allZero) return 7'h00;
    return SEG_TABLE[snapD[dg]];
  endfunction

  // One clock of stimulus; the model predicts what the DUT shows after this edge.
  task automatic applyStimulus(input bit rst, input bit en, input logic [4*ND-1:0] bcd,
                               input bit ld, input bit blz);
    expT e;
    int  dg;
    bit  bnd;
    resetIn   = rst;
    enableIn  = en;
    bcdIn     = bcd;
    loadIn    = ld;
    blankLzIn = blz;
    e = '0;
    if (rst) begin
      framePos = 0;
      pend     = 1'b0;
      for (int i = 0; i < ND; i++) begin
        snapD[i]  = 0;
        stageD[i] = 0;
      end
    end else begin
      dg  = framePos / RD;
      bnd = en && (framePos == FRAME - 1);
      if (en) begin
        e.sel[dg] = 1'b1;
        e.seg     = expectedSeg(dg, blz);
      end
      e.fd = bnd;
      if (ld && bnd) begin
        for (int i = 0; i < ND; i++) snapD[i] = int'(bcd[4*i +: 4]);
        pend = 1'b0;
      end else if (bnd && pend) begin
        for (int i = 0; i < ND; i++) snapD[i] = stageD[i];
        pend = 1'b0;
      end else if (ld) begin
        for (int i = 0; i < ND; i++) stageD[i] = int'(bcd[4*i +: 4]);
        pend = 1'b1;
      end
      if (en) framePos = (framePos + 1) % FRAME;
    end
    @(posedge clk);
    expQ.push_back(e);
    #2;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, '0, 1'b0, blzMode);
  endtask

  // Advance (bounded by one frame) until the frame position matches, then load.
  task automatic loadAt(input int pos, input logic [4*ND-1:0] value);
    for (int i = 0; i < FRAME && framePos != pos; i++) runCycles(1);
    applyStimulus(1'b0, 1'b1, value, 1'b1, blzMode);
  endtask

  task automatic checkOutput(input expT e);
    checks++;
    if ({segOut, digitSelOut, frameDoneOut} !== e) begin
      errors++;
      $display("[TB] FAIL scan_out cycle %0d: got seg=%h sel=%b fd=%b, expected seg=%h sel=%b fd=%b",
               cycle, segOut, digitSelOut, frameDoneOut, e.seg, e.sel, e.fd);
    end
  endtask

  initial begin
    expT e;
    forever begin
      @(negedge clk);
      cycle++;
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    logic [4*ND-1:0] rnd;
    for (int i = 0; i < ND; i++) begin
      snapD[i]  = 0;
      stageD[i] = 0;
    end

    // Reset overrides enable; then scan from digit 0 showing zeros
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 16'h9999, 1'b1, 1'b0);
    runCycles(2 * FRAME + 3);

    // Mid-frame load while idx=1
    loadAt(1 * RD + 1, 16'h1234);
    runCycles(2 * FRAME);

    // Leading-zero blanking and invalid codes
    blzMode = 1'b1;
    loadAt(5, 16'h0070);
    runCycles(2 * FRAME);
    loadAt(3, 16'h0000);
    runCycles(2 * FRAME);
    loadAt(9, 16'h00A0);
    runCycles(2 * FRAME);
    blzMode = 1'b0;

    // Last load in a frame wins; a boundary load shows immediately after
    loadAt(2, 16'h5555);
    runCycles(3);
    applyStimulus(1'b0, 1'b1, 16'h0009, 1'b1, 1'b0);
    runCycles(2 * FRAME);
    loadAt(FRAME - 1, 16'h0008);
    runCycles(FRAME);

    // Enable gap at presc=2
    for (int i = 0; i < RD && (framePos % RD) != 2; i++) runCycles(1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    runCycles(2 * FRAME);

    // Reset while a load is pending
    loadAt(6, 16'h7777);
    runCycles(2);
    applyStimulus(1'b1, 1'b1, '0, 1'b0, 1'b0);
    runCycles(2 * FRAME);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < ND; d++)
        rnd[4*d +: 4] = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15))
                                            : 4'($urandom_range(0, 9));
      if ($urandom % 3 == 0) rnd[4*ND-1:8] = '0;
      if ($urandom % 200 == 0) blzMode = ~blzMode;
      applyStimulus(($urandom % 300) == 0, ($urandom % 10) != 0, rnd,
                    ($urandom % 12) == 0, blzMode);
    end

    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain: %0d entries left, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
